// File: rtl/mips_datapath_execute_memory_stage.sv
// Execute-to-memory pipeline register with alignment/range checking and store lane replication.
// Latency: one cycle, all outputs registered.
// Backpressure: stall holds every register except fault_ack handling; flush forces a bubble even while stalled.
package mips_datapath_pkg;

    typedef struct packed {
        logic clk;
        logic rst_n;
    } Data_Control_Control_T;

    typedef enum logic [1:0] {
        BE_NONE = 2'd0,
        BE_BYTE = 2'd1,
        BE_HALF = 2'd2,
        BE_WORD = 2'd3
    } byte_enable_t;

    typedef enum logic {
        EXT_UNSIGNED = 1'b0,
        EXT_SIGNED   = 1'b1
    } byte_extend_t;

    typedef struct packed {
        byte_enable_t byte_enable;
        byte_extend_t byte_extend;
        logic         write_enable;
    } Mips_Control_IfId_Signal_Memory_Control_T;

    localparam Mips_Control_IfId_Signal_Memory_Control_T MEM_CTRL_BUBBLE =
        '{byte_enable: BE_NONE, byte_extend: EXT_UNSIGNED, write_enable: 1'b0};

    function automatic int Util_Math_log2(input int n);
        return $clog2(n);
    endfunction

endpackage

module mips_datapath_execute_memory_stage
    import mips_datapath_pkg::*;
#(
    parameter int ADDR_L = 64,
    parameter int ADDR_W = Util_Math_log2(ADDR_L)
) (
    input  Data_Control_Control_T                    ctrl,
    input  logic                                     stall,
    input  logic                                     flush,
    input  logic                                     in_valid,
    input  Mips_Control_IfId_Signal_Memory_Control_T in_control,
    input  logic [31:0]                              in_addr,
    input  logic [31:0]                              in_data,
    input  logic [4:0]                               in_dest,
    input  logic                                     fault_ack,
    output logic                                     out_valid,
    output Mips_Control_IfId_Signal_Memory_Control_T out_control,
    output logic [ADDR_W+1:0]                        out_addr,
    output logic [31:0]                              out_data,
    output logic [4:0]                               out_dest,
    output logic                                     fault,
    output logic [31:0]                              fault_addr,
    output logic [7:0]                               fault_count
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    logic        clk;
    logic        rst_n;
    logic        misaligned;
    logic        out_of_range;
    logic        fault_det;
    logic        bubble;
    logic [31:0] lane_data;
    state_t      state;
    state_t      state_nxt;
    logic        capture;

    assign clk   = ctrl.clk;
    assign rst_n = ctrl.rst_n;

    assign misaligned   = ((in_control.byte_enable == BE_HALF) && in_addr[0]) ||
                          ((in_control.byte_enable == BE_WORD) && (in_addr[1:0] != 2'b00));
    assign out_of_range = (in_addr >> (ADDR_W + 2)) != 32'd0;
    assign fault_det    = !stall && !flush && in_valid &&
                          (in_control.byte_enable != BE_NONE) && (misaligned || out_of_range);

    // Flush wins over stall; a faulting access is squashed into a bubble.
    assign bubble = flush || (!stall && (!in_valid || fault_det));

    always_comb begin
        lane_data = in_data;
        case (in_control.byte_enable)
            BE_BYTE: lane_data = {4{in_data[7:0]}};
            BE_HALF: lane_data = {2{in_data[15:0]}};
            default: lane_data = in_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_control <= MEM_CTRL_BUBBLE;
            out_addr    <= '0;
            out_data    <= '0;
            out_dest    <= '0;
        end else if (bubble) begin
            out_valid   <= 1'b0;
            out_control <= MEM_CTRL_BUBBLE;
            out_addr    <= '0;
            out_data    <= '0;
            out_dest    <= '0;
        end else if (!stall) begin
            out_valid   <= 1'b1;
            out_control <= in_control;
            out_addr    <= in_addr[ADDR_W+1:0];
            out_data    <= lane_data;
            out_dest    <= in_dest;
        end
    end

    // fault_det is already gated by stall, so only fault_ack can move the FSM while stalled.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fault_det) begin
                    state_nxt = S_FAULT;
                    capture   = 1'b1;
                end
            end
            S_FAULT: begin
                if (fault_ack && fault_det) begin
                    capture = 1'b1;
                end else if (fault_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            fault_addr  <= '0;
            fault_count <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                fault_addr <= in_addr;
            end
            if (fault_det && (fault_count != 8'hFF)) begin
                fault_count <= fault_count + 8'd1;
            end
        end
    end

    assign fault = (state == S_FAULT);

endmodule

// File: tb/tb_mips_datapath_execute_memory_stage.sv
// Bench for the execute/memory pipeline register: directed scenarios followed by random traffic,
// each cycle compared against an arithmetic reference model.
module tb_mips_datapath_execute_memory_stage;
    import mips_datapath_pkg::*;

    localparam int ADDR_L = 64;
    localparam int ADDR_W = 6;
    localparam int MEM_BYTES = 4 * ADDR_L;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    Data_Control_Control_T ctrl;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    Mips_Control_IfId_Signal_Memory_Control_T in_control = MEM_CTRL_BUBBLE;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic [4:0]  in_dest = '0;
    logic        fault_ack = 1'b0;
    logic        out_valid;
    Mips_Control_IfId_Signal_Memory_Control_T out_control;
    logic [ADDR_W+1:0] out_addr;
    logic [31:0] out_data;
    logic [4:0]  out_dest;
    logic        fault;
    logic [31:0] fault_addr;
    logic [7:0]  fault_count;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic        m_valid;
    logic [3:0]  m_ctrl;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [4:0]  m_dest;
    logic        m_fault;
    logic [31:0] m_faddr;
    int          m_fcount;

    assign ctrl = '{clk: clk, rst_n: rst_n};

    always #5 clk = ~clk;

    mips_datapath_execute_memory_stage #(.ADDR_L(ADDR_L), .ADDR_W(ADDR_W)) dut (
        .ctrl(ctrl), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_control(in_control), .in_addr(in_addr), .in_data(in_data), .in_dest(in_dest),
        .fault_ack(fault_ack), .out_valid(out_valid), .out_control(out_control),
        .out_addr(out_addr), .out_data(out_data), .out_dest(out_dest), .fault(fault),
        .fault_addr(fault_addr), .fault_count(fault_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_ctrl = 4'b0; m_addr = 0; m_data = 0; m_dest = 0;
        m_fault = 1'b0; m_faddr = 0; m_fcount = 0;
    endtask

    task automatic model_bubble();
        m_valid = 1'b0; m_ctrl = 4'b0; m_addr = 0; m_data = 0; m_dest = 0;
    endtask

    // Applies the stage rules to the inputs currently present, as the coming edge will.
    task automatic model_step();
        int  be;
        bit  bad;
        bit  flt;
        be  = int'(in_control.byte_enable);
        bad = (be == 2 && (in_addr % 2) != 0) || (be == 3 && (in_addr % 4) != 0) ||
              (longint'(in_addr) >= MEM_BYTES);
        flt = !stall && !flush && in_valid && be != 0 && bad;
        if (flush) begin
            model_bubble();
        end else if (!stall) begin
            if (!in_valid || flt) begin
                model_bubble();
            end else begin
                m_valid = 1'b1;
                m_ctrl  = in_control;
                m_addr  = in_addr % MEM_BYTES;
                m_dest  = in_dest;
                if (be == 1)      m_data = (in_data % 256) * 32'h0101_0101;
                else if (be == 2) m_data = (in_data % 65536) * 32'h0001_0001;
                else              m_data = in_data;
            end
        end
        if (flt) begin
            if (!m_fault || fault_ack) m_faddr = in_addr;
            m_fault = 1'b1;
            if (m_fcount < 255) m_fcount++;
        end else if (fault_ack) begin
            m_fault = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},  {31'b0, out_valid}, {31'b0, m_valid});
        check({tag, ".ctrl"},   {28'b0, out_control}, {28'b0, m_ctrl});
        check({tag, ".addr"},   {24'b0, out_addr}, m_addr);
        check({tag, ".data"},   out_data, m_data);
        check({tag, ".dest"},   {27'b0, out_dest}, {27'b0, m_dest});
        check({tag, ".fault"},  {31'b0, fault}, {31'b0, m_fault});
        check({tag, ".faddr"},  fault_addr, m_faddr);
        check({tag, ".fcount"}, {24'b0, fault_count}, m_fcount);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit v, input int be, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd);
        in_valid   = v;
        in_control = '{byte_enable: byte_enable_t'(be), byte_extend: EXT_UNSIGNED, write_enable: we};
        in_addr    = a;
        in_data    = d;
        in_dest    = rd;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset_init");
        @(negedge clk);
        rst_n = 1'b1;

        drive(1, 1, 1, 32'h5, 32'h1234_56AB, 5'd3);
        tick("byte_store");
        check("byte_data_value", out_data, 32'hABAB_ABAB);
        check("byte_addr_value", {24'b0, out_addr}, 32'h5);

        drive(1, 2, 1, 32'h4, 32'h1234_56AB, 5'd4);
        tick("half_store");
        check("half_data_value", out_data, 32'h56AB_56AB);

        drive(1, 3, 1, 32'h6, 32'hDEAD_BEEF, 5'd5);
        tick("word_misaligned");
        check("word_fault_we", {31'b0, out_control.write_enable}, 32'h0);
        check("word_fault_flag", {31'b0, fault}, 32'h1);
        check("word_fault_addr", fault_addr, 32'h6);

        drive(1, 1, 1, 32'h101, 32'h0, 5'd6);
        tick("out_of_range");
        check("oor_addr_held", fault_addr, 32'h6);
        check("oor_count", {24'b0, fault_count}, 32'd2);

        drive(0, 0, 0, 32'h0, 32'h0, 5'd0);
        fault_ack = 1'b1;
        tick("ack_alone");
        check("ack_clears", {31'b0, fault}, 32'h0);
        fault_ack = 1'b0;

        drive(1, 3, 1, 32'h2, 32'h0, 5'd7);
        tick("refault");
        drive(1, 2, 0, 32'h3, 32'h0, 5'd8);
        fault_ack = 1'b1;
        tick("ack_with_fault");
        check("ack_fault_flag", {31'b0, fault}, 32'h1);
        check("ack_fault_addr", fault_addr, 32'h3);
        fault_ack = 1'b0;

        drive(1, 1, 1, 32'h8, 32'h0000_00CD, 5'd9);
        tick("pre_stall");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 1, 32'h10 + 32'(4 * i), $urandom, 5'(i + 10));
            tick("stall_hold");
            check("stall_frozen", out_data, 32'hCDCD_CDCD);
        end
        flush = 1'b1;
        tick("stall_flush");
        check("stall_flush_bubble", {31'b0, out_valid}, 32'h0);
        stall = 1'b0;
        flush = 1'b0;

        for (int i = 0; i < 256; i++) begin
            drive(1, 3, 1, 32'h1 + 32'(4 * i), 32'h0, 5'd1);
            model_step();
            @(posedge clk);
            #1;
        end
        check_all("saturate");
        check("saturate_value", {24'b0, fault_count}, 32'd255);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            stall     = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            fault_ack = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 5) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                  (r == 0) ? $urandom : 32'($urandom_range(0, 300)), $urandom, 5'($urandom));
            in_control.byte_extend = byte_extend_t'($urandom_range(0, 1));
            tick("random");
        end
        stall = 1'b0; flush = 1'b0; fault_ack = 1'b0;

        drive(1, 3, 1, 32'h7, 32'h0, 5'd2);
        tick("pre_reset_fault");
        drive(1, 3, 1, 32'h20, 32'hCAFE_F00D, 5'd12);
        tick("pre_reset_valid");
        check("pre_reset_both", {30'b0, out_valid, fault}, 32'h3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        check("async_reset_count", {24'b0, fault_count}, 32'd0);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0);
        tick("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_datapath_execute_memory_stage.md
# mips_datapath_execute_memory_stage

Pipeline register between the execute stage and the data-memory stage of the pipelined MIPS datapath. It captures the ALU-computed address, the store operand, the memory control bundle and the destination register. It checks each access for alignment and range, and replicates store data across byte lanes. It drives the memory stage directly, supporting stall and flush, and reports faults through a sticky flag with acknowledge.

## Interface

Parameters:
- `ADDR_L`, 64, data memory depth in 32-bit words.
- `ADDR_W`, `Util_Math_log2(ADDR_L)`, word-address width.

Ports:
- `ctrl`  input  `Data_Control_Control_T`  clock (rising edge) and reset; one clock; reset is asynchronous and active-low.
- `stall`  input  1  hold all stage registers.
- `flush`  input  1  replace the incoming instruction with a bubble.
- `in_valid`  input  1  execute stage holds a real instruction.
- `in_control`  input  `Mips_Control_IfId_Signal_Memory_Control_T`  ByteEnable / ByteExtend / WriteEnable from decode.
- `in_addr`  input  32  ALU result (byte address).
- `in_data`  input  32  store operand (rt).
- `in_dest`  input  5  writeback register number.
- `fault_ack`  input  1  clears the sticky fault.
- `out_valid`  output  1  memory stage holds a real instruction.
- `out_control`  output  `Mips_Control_IfId_Signal_Memory_Control_T`  to the memory stage.
- `out_addr`  output  ADDR_W+2  byte address to the memory stage.
- `out_data`  output  32  lane-replicated store data.
- `out_dest`  output  5  registered destination.
- `fault`  output  1  sticky misaligned or out-of-range access.
- `fault_addr`  output  32  full address of the first unacknowledged fault.
- `fault_count`  output  8  saturating count of faults since reset.

## Operation

- Load condition: `!stall`. When loading:
  - If `flush`, or `!in_valid`, or the access faults, register a bubble.
  - Otherwise register the inputs.
- Bubble values: `out_valid`=0, ByteEnable=None, WriteEnable deasserted, ByteExtend=Unsigned, `out_addr`=0, `out_data`=0, `out_dest`=0.
- Priority: reset > flush > stall > load. `flush` with `stall` gives a bubble at the next edge.
- Fault checks apply only when loading, `in_valid`=1, `flush`=0, and ByteEnable≠None:
  - Half faults when `in_addr[0]`=1.
  - Word faults when `in_addr[1:0]`≠0.
  - Byte, Half or Word faults when `in_addr` ≥ 4·ADDR_L, meaning any bit above ADDR_W+1 is set.
- Store lane replication (combinational, then registered):
  - Byte: `{4{in_data[7:0]}}`.
  - Half: `{2{in_data[15:0]}}`.
  - Word and None: `in_data` unchanged.
- `out_addr` = `in_addr[ADDR_W+1:0]`.
- Fault FSM:
  - IDLE: `fault`=0. On a fault, go to FAULT and capture `fault_addr`=`in_addr`.
  - FAULT: `fault`=1 and `fault_addr` is held. Further faults do not overwrite `fault_addr`.
  - FAULT with `fault_ack`=1 and no new fault: go to IDLE.
  - FAULT with `fault_ack`=1 and a new fault in the same cycle: stay in FAULT and capture the new address.
  - `fault_ack` in IDLE has no effect.
- `fault_count` increments on every detected fault and saturates at 255. It is not cleared by `fault_ack`.

## Timing

- Latency: one cycle from inputs to `out_*`. All outputs are registered; there is no combinational path from inputs to outputs.
- Reset (asynchronous, active-low) forces immediately, without waiting for a clock edge:
  - all `out_*` to bubble values;
  - `fault`=0, `fault_addr`=0, `fault_count`=0, FSM in IDLE.
- Reset mid-fault clears the FSM with no pending acknowledge.
- During `stall`, every register holds, including the FSM. Exception: `fault_ack` is still honoured while stalled.
- A faulting instruction never reaches the memory stage with WriteEnable asserted. `fault` rises on the same edge that registers its bubble.

## Test plan

- Reset asserted mid-stream with `out_valid`=1 and `fault`=1 → all outputs zero or bubble immediately, before the next edge; `fault_count`=0.
- Byte store, `in_addr`=0x0000_0005, `in_data`=0x1234_56AB → next cycle `out_data`=0xABAB_ABAB, `out_addr`=5, `out_valid`=1. Repeat as Half with `in_addr`=4: `out_data`=0x56AB_56AB.
- Word store at `in_addr`=0x0000_0006 → bubble with WriteEnable=0, `fault`=1, `fault_addr`=0x6, `fault_count`=1. A second fault at 0x101 (out of range for ADDR_L=64) → `fault_addr` stays 0x6, `fault_count`=2.
- In FAULT: `fault_ack` alone → `fault`=0 next cycle. `fault_ack` together with a new Half fault at 0x3 → `fault` stays 1, `fault_addr`=0x3.
- `stall`=1 for 3 cycles with changing inputs → outputs frozen. Then `stall`=1 with `flush`=1 → bubble next cycle.
- 256 consecutive faulting accesses → `fault_count` saturates at 255.
